// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS x 32-bit registers, byte-strobed
// writes, AW/W accepted in either order, SLVERR on out-of-range accesses.
// Register 0 drives the board-level LED output.
module axi_lite_regbank #(
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 32,
   parameter int LED_W    = 16
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic [ADDR_W-1:0] AWADDR,
   input  logic              AWVALID,
   output logic              AWREADY,
   input  logic [31:0]       WDATA,
   input  logic [3:0]        WSTRB,
   input  logic              WVALID,
   output logic              WREADY,
   output logic [1:0]        BRESP,
   output logic              BVALID,
   input  logic              BREADY,
   input  logic [ADDR_W-1:0] ARADDR,
   input  logic              ARVALID,
   output logic              ARREADY,
   output logic [31:0]       RDATA,
   output logic [1:0]        RRESP,
   output logic              RVALID,
   input  logic              RREADY,
   output logic [LED_W-1:0]  led
);

   localparam int         IDX_W       = $clog2(NUM_REGS);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      WR_IDLE      = 2'd0,
      WR_ADDR_ONLY = 2'd1,
      WR_DATA_ONLY = 2'd2,
      WR_BOTH      = 2'd3
   } wr_state_t;

   // Returns {in_range, word_index}; byte offset bits [1:0] are ignored.
   function automatic logic [IDX_W:0] decode_f(input logic [ADDR_W-1:0] a);
      logic ok;
      ok = ((a >> (IDX_W + 2)) == {ADDR_W{1'b0}});
      decode_f = {ok, a[IDX_W+1:2]};
   endfunction

   logic [31:0]      regs_r [NUM_REGS];

   wr_state_t        wr_state_r;
   logic             awready_r;
   logic             wready_r;
   logic [IDX_W-1:0] aw_idx_r;
   logic             aw_ok_r;
   logic [31:0]      wdata_r;
   logic [3:0]       wstrb_r;
   logic             bvalid_r;
   logic [1:0]       bresp_r;

   logic             arready_r;
   logic             rvalid_r;
   logic [31:0]      rdata_r;
   logic [1:0]       rresp_r;

   logic [IDX_W:0]   aw_dec_s;
   logic [IDX_W:0]   ar_dec_s;
   logic             aw_hs_s;
   logic             w_hs_s;
   logic             ar_hs_s;
   logic             commit_s;

   assign aw_dec_s = decode_f(AWADDR);
   assign ar_dec_s = decode_f(ARADDR);
   assign aw_hs_s  = AWVALID && awready_r;
   assign w_hs_s   = WVALID && wready_r;
   assign ar_hs_s  = ARVALID && arready_r;
   // A commit never overwrites a response that has not yet been accepted.
   assign commit_s = (wr_state_r == WR_BOTH) && !bvalid_r;

   // Write channel FSM: tracks which of AW/W is held, owns the ready flops and the B response.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_state_r <= WR_IDLE;
         awready_r  <= 1'b0;
         wready_r   <= 1'b0;
         aw_idx_r   <= {IDX_W{1'b0}};
         aw_ok_r    <= 1'b0;
         wdata_r    <= 32'h0000_0000;
         wstrb_r    <= 4'h0;
         bvalid_r   <= 1'b0;
         bresp_r    <= RESP_OKAY;
      end else begin
         if (aw_hs_s) begin
            aw_idx_r <= aw_dec_s[IDX_W-1:0];
            aw_ok_r  <= aw_dec_s[IDX_W];
         end
         if (w_hs_s) begin
            wdata_r <= WDATA;
            wstrb_r <= WSTRB;
         end
         if (bvalid_r && BREADY) begin
            bvalid_r <= 1'b0;
         end
         case (wr_state_r)
            WR_IDLE: begin
               if (aw_hs_s && w_hs_s) begin
                  wr_state_r <= WR_BOTH;
                  awready_r  <= 1'b0;
                  wready_r   <= 1'b0;
               end else if (aw_hs_s) begin
                  wr_state_r <= WR_ADDR_ONLY;
                  awready_r  <= 1'b0;
                  wready_r   <= 1'b1;
               end else if (w_hs_s) begin
                  wr_state_r <= WR_DATA_ONLY;
                  awready_r  <= 1'b1;
                  wready_r   <= 1'b0;
               end else begin
                  wr_state_r <= WR_IDLE;
                  awready_r  <= 1'b1;
                  wready_r   <= 1'b1;
               end
            end
            WR_ADDR_ONLY: begin
               if (w_hs_s) begin
                  wr_state_r <= WR_BOTH;
                  awready_r  <= 1'b0;
                  wready_r   <= 1'b0;
               end else begin
                  wr_state_r <= WR_ADDR_ONLY;
                  awready_r  <= 1'b0;
                  wready_r   <= 1'b1;
               end
            end
            WR_DATA_ONLY: begin
               if (aw_hs_s) begin
                  wr_state_r <= WR_BOTH;
                  awready_r  <= 1'b0;
                  wready_r   <= 1'b0;
               end else begin
                  wr_state_r <= WR_DATA_ONLY;
                  awready_r  <= 1'b1;
                  wready_r   <= 1'b0;
               end
            end
            WR_BOTH: begin
               if (!bvalid_r) begin
                  wr_state_r <= WR_IDLE;
                  awready_r  <= 1'b1;
                  wready_r   <= 1'b1;
                  bvalid_r   <= 1'b1;
                  bresp_r    <= aw_ok_r ? RESP_OKAY : RESP_SLVERR;
               end else begin
                  wr_state_r <= WR_BOTH;
                  awready_r  <= 1'b0;
                  wready_r   <= 1'b0;
               end
            end
            default: begin
               wr_state_r <= WR_IDLE;
               awready_r  <= 1'b0;
               wready_r   <= 1'b0;
            end
         endcase
      end
   end

   // Register storage: byte-lane update of the addressed word on an in-range commit.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= 32'h0000_0000;
         end
      end else if (commit_s && aw_ok_r) begin
         for (int k = 0; k < 4; k++) begin
            if (wstrb_r[k]) begin
               regs_r[aw_idx_r][8*k +: 8] <= wdata_r[8*k +: 8];
            end
         end
      end
   end

   // Read channel: captures the pre-write register value on AR and holds it until R is accepted.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         arready_r <= 1'b0;
         rvalid_r  <= 1'b0;
         rdata_r   <= 32'h0000_0000;
         rresp_r   <= RESP_OKAY;
      end else if (ar_hs_s) begin
         arready_r <= 1'b0;
         rvalid_r  <= 1'b1;
         rdata_r   <= ar_dec_s[IDX_W] ? regs_r[ar_dec_s[IDX_W-1:0]] : 32'h0000_0000;
         rresp_r   <= ar_dec_s[IDX_W] ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_r && RREADY) begin
         arready_r <= 1'b1;
         rvalid_r  <= 1'b0;
      end else begin
         arready_r <= !rvalid_r;
      end
   end

   assign AWREADY = awready_r;
   assign WREADY  = wready_r;
   assign BVALID  = bvalid_r;
   assign BRESP   = bresp_r;
   assign ARREADY = arready_r;
   assign RVALID  = rvalid_r;
   assign RDATA   = rdata_r;
   assign RRESP   = rresp_r;
   assign led     = regs_r[0][LED_W-1:0];

endmodule
